// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver: FSM encodings and default bit timing.
package uart_byte_rx_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit; the reset value is a
// parameter so idle-high lines (UART rx) and idle-low lines (buttons) both fit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: plain shift through the two stages
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchroniser registers, synchronous active-low reset to RST_VAL
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises the pin, validates the start bit at half-bit,
// samples the 8 data bits and the stop bit at mid-bit, and emits one-cycle
// o_rx_done / o_frame_err strobes.
//
// Handshake: o_rx_done is a one-cycle valid strobe with no ready; o_data is
// valid in the strobe cycle and held until the next good byte. The consumer
// must accept every strobe.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy,
  output state_t     o_state
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  logic          rx_d_q, rx_d_d;
  logic          fell;
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // A line held low produces no edge, so it cannot re-trigger the FSM
  assign fell = rx_d_q & ~rx_s;

  // Next-state and datapath: start validation, mid-bit sampling, stop check
  always_comb begin
    rx_d_d    = rx_s;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (fell) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // Still low at half-bit: genuine start; otherwise a glitch
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          // LSB arrives first, so shift in from the MSB end
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          // Leaving at mid-stop-bit leaves room to catch a back-to-back start
          state_d   = S_IDLE;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      rx_d_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_d_q    <= rx_d_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_state     = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx with CLKS_PER_BIT=16 and a 20 ns clock.
module tb_uart_byte_rx;
  import uart_byte_rx_pkg::*;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;
  state_t     o_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         done_cyc_q[$];
  logic [7:0] done_data_q[$];
  logic       done_busy_q[$];
  int         ferr_cnt = 0;
  logic       prev_strobe = 1'b0;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records events, checks exclusivity and single-cycle width
  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cyc_q.push_back(cyc);
      done_data_q.push_back(o_data);
      done_busy_q.push_back(o_busy);
    end
    if (o_frame_err) ferr_cnt = ferr_cnt + 1;
    if (o_rx_done || o_frame_err) begin
      checks = checks + 1;
      if ((o_rx_done && o_frame_err) || prev_strobe) begin
        errors = errors + 1;
        $display("FAIL strobe_shape cyc=%0d done=%b ferr=%b prev=%b (need single exclusive pulse)",
                 cyc, o_rx_done, o_frame_err, prev_strobe);
      end
    end
    prev_strobe = o_rx_done | o_frame_err;
  end

  // Drive one frame; returns the first cycle at which rx is low. Caller is #1 after an edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a number of recorded rx_done strobes
  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cyc_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cyc_q.size() < n) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_done timeout got=%0d need=%0d", done_cyc_q.size(), n);
    end
  endtask

  task automatic clear_log();
    done_cyc_q  = {};
    done_data_q = {};
    done_busy_q = {};
    ferr_cnt    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (o_data !== 8'h00)    begin errors++; $display("FAIL reset_data got=%h exp=00", o_data); end
    if (o_rx_done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", o_rx_done); end
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
    if (o_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    if (o_state !== S_IDLE)  begin errors++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int t0, lat;
    clear_log();
    send_byte(8'h5A, 1'b1, t0);
    wait_done(1, 400);
    repeat (20) @(posedge clk);
    #1;
    checks += 5;
    if (done_cyc_q.size() != 1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", done_cyc_q.size());
    end
    if (done_cyc_q.size() >= 1) begin
      lat = done_cyc_q[0] - t0;
      if (done_data_q[0] !== 8'h5A) begin errors++; $display("FAIL single_data got=%h exp=5A", done_data_q[0]); end
      if (lat < 153 || lat > 155)  begin errors++; $display("FAIL single_latency got=%0d exp=154+-1", lat); end
      if (done_busy_q[0] !== 1'b0) begin errors++; $display("FAIL single_busy_drop got=%b exp=0", done_busy_q[0]); end
    end else begin
      errors += 3;
      $display("FAIL single_no_strobe got=none exp=5A");
    end
    if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, gap;
    clear_log();
    send_byte(8'h00, 1'b1, t0);
    send_byte(8'hFF, 1'b1, t1);
    wait_done(2, 400);
    repeat (20) @(posedge clk);
    #1;
    checks += 4;
    if (done_cyc_q.size() != 2) begin
      errors++; $display("FAIL b2b_count got=%0d exp=2", done_cyc_q.size());
    end
    if (done_cyc_q.size() >= 2) begin
      gap = done_cyc_q[1] - done_cyc_q[0];
      if (done_data_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got=%h exp=00", done_data_q[0]); end
      if (done_data_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got=%h exp=FF", done_data_q[1]); end
      if (gap < 159 || gap > 161)   begin errors++; $display("FAIL b2b_gap got=%0d exp=160+-1", gap); end
    end else begin
      errors += 3;
      $display("FAIL b2b_missing got=%0d strobes exp=2", done_cyc_q.size());
    end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    clear_log();
    busy_cnt = 0;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    #1;
    checks += 5;
    if (busy_cnt == 0 || busy_cnt > 8) begin errors++; $display("FAIL glitch_busy got=%0d exp=1..8", busy_cnt); end
    if (done_cyc_q.size() != 0) begin errors++; $display("FAIL glitch_done got=%0d exp=0", done_cyc_q.size()); end
    if (ferr_cnt != 0)          begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt); end
    if (o_state !== S_IDLE)     begin errors++; $display("FAIL glitch_state got=%0d exp=0", o_state); end
    if (o_data !== 8'hFF)       begin errors++; $display("FAIL glitch_data got=%h exp=FF", o_data); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_log();
    send_byte(8'hA5, 1'b0, t0);
    repeat (50) @(posedge clk);
    #1;
    checks += 3;
    if (ferr_cnt != 1)          begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    if (done_cyc_q.size() != 0) begin errors++; $display("FAIL ferr_done got=%0d exp=0", done_cyc_q.size()); end
    if (o_data !== 8'hFF)       begin errors++; $display("FAIL ferr_data_hold got=%h exp=FF", o_data); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_byte(8'h3C, 1'b1, t0);
    wait_done(1, 400);
    repeat (10) @(posedge clk);
    #1;
    checks += 3;
    if (done_cyc_q.size() != 1) begin errors++; $display("FAIL ferr_recover_count got=%0d exp=1", done_cyc_q.size()); end
    if (o_data !== 8'h3C)       begin errors++; $display("FAIL ferr_recover_data got=%h exp=3C", o_data); end
    if (ferr_cnt != 1)          begin errors++; $display("FAIL ferr_recover_ferr got=%0d exp=1", ferr_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int t0;
    clear_log();
    // 0xF0: bits 4..7 and stop are high, so the tail after reset has no falling edge
    b  = 8'hF0;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = b[4];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks += 4;
    if (o_data !== 8'h00)    begin errors++; $display("FAIL rstmid_data got=%h exp=00", o_data); end
    if (o_busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    if (o_rx_done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b exp=0", o_rx_done); end
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", o_frame_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks += 2;
    if (done_cyc_q.size() != 0) begin errors++; $display("FAIL rstmid_tail_done got=%0d exp=0", done_cyc_q.size()); end
    if (ferr_cnt != 0)          begin errors++; $display("FAIL rstmid_tail_ferr got=%0d exp=0", ferr_cnt); end
    send_byte(8'h81, 1'b1, t0);
    wait_done(1, 400);
    repeat (10) @(posedge clk);
    #1;
    checks += 2;
    if (done_cyc_q.size() != 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", done_cyc_q.size()); end
    if (o_data !== 8'h81)       begin errors++; $display("FAIL rstmid_next_data got=%h exp=81", o_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
